// File: rtl/matmul_pkg.sv
// Shared definitions for the SPI 2x2 matrix-multiply slave.
//   - FSM state encodings (IDLE/RX/COMPUTE/TX/DONE)
//   - frame geometry: bytes written (A0..A3, B0..B3) and bytes read (C0..C3)
//   - element index maps selecting the A/B operands for each result Ck
package matmul_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RX      = 3'd1;
    localparam logic [2:0] ST_COMPUTE = 3'd2;
    localparam logic [2:0] ST_TX      = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam int N_IN_BYTES   = 8;
    localparam int N_OUT_BYTES  = 4;
    // byte_cnt stops here once every result byte has been shifted out
    localparam int BYTE_CNT_MAX = N_IN_BYTES + N_OUT_BYTES;

    // Ck = A[a0]*B[b0] + A[a1]*B[b1], with k = {row, col} of the 2x2 result
    function automatic logic [1:0] idx_a0(input logic [1:0] k);
        return {k[1], 1'b0};
    endfunction

    function automatic logic [1:0] idx_a1(input logic [1:0] k);
        return {k[1], 1'b1};
    endfunction

    function automatic logic [1:0] idx_b0(input logic [1:0] k);
        return {1'b0, k[0]};
    endfunction

    function automatic logic [1:0] idx_b1(input logic [1:0] k);
        return {1'b1, k[0]};
    endfunction

endpackage

// File: rtl/matmul_dot2.sv
// Combinational two-term dot product y = a*b + c*d for the matrix multiplier.
// Products are 2*DATA_W bits, the sum 2*DATA_W+1 bits; the result is reduced
// to DATA_W bits by saturation (MATMUL_SAT_EN defined) or by truncation
// (default build).
// Ports:
//   i_a, i_b, i_c, i_d  in   DATA_W  unsigned operands
//   o_y                 out  DATA_W  reduced sum
module matmul_dot2 #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_c,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_y
);

    logic [2*DATA_W-1:0] w_p0;
    logic [2*DATA_W-1:0] w_p1;
    logic [2*DATA_W:0]   w_sum;

    function automatic logic [DATA_W-1:0] reduce(input logic [2*DATA_W:0] s);
`ifdef MATMUL_SAT_EN
        return (s > (2*DATA_W+1)'({DATA_W{1'b1}})) ? {DATA_W{1'b1}} : DATA_W'(s);
`else
        return DATA_W'(s);
`endif
    endfunction

    assign w_p0  = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
    assign w_p1  = (2*DATA_W)'(i_c) * (2*DATA_W)'(i_d);
    assign w_sum = (2*DATA_W+1)'(w_p0) + (2*DATA_W+1)'(w_p1);
    assign o_y   = reduce(w_sum);

endmodule

// File: rtl/spi_matmul_slave.sv
// SPI slave 2x2 matrix multiplier. One CSB-low frame carries 8 write bytes
// (A0..A3, B0..B3, row-major, MSB first) followed by 4 read bytes (C0..C3).
// All SPI pins are oversampled by clk; nothing is clocked by spi_sck.
// Optional build macro: MATMUL_SAT_EN (saturate results instead of wrapping).
// Ports:
//   clk           in   1  system clock
//   resetn        in   1  asynchronous active-low reset
//   spi_csb       in   1  chip select, active low
//   spi_sck       in   1  SPI clock, idle low
//   spi_sdi       in   1  MOSI, sampled on synchronised sck rise
//   spi_sdo       out  1  MISO, shifted on synchronised sck fall
//   busy          out  1  transaction in progress
//   result_valid  out  1  C0..C3 hold the last completed compute
module spi_matmul_slave
    import matmul_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic spi_csb,
    input  logic spi_sck,
    input  logic spi_sdi,
    output logic spi_sdo,
    output logic busy,
    output logic result_valid
);

    logic [SYNC_STAGES-1:0] r_csb_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sck_d;

    logic [2:0]        r_state;
    logic [3:0]        r_byte_cnt;
    logic [2:0]        r_bit_cnt;
    logic [1:0]        r_cmp_cnt;
    logic [DATA_W-2:0] r_rx_sr;
    logic [DATA_W-1:0] r_tx_sr;
    logic [DATA_W-1:0] r_a [4];
    logic [DATA_W-1:0] r_b [4];
    logic [DATA_W-1:0] r_c [4];
    logic              r_busy;
    logic              r_valid;
    logic              r_rise_seen;

    logic              w_csb, w_sck, w_sdi, w_rise, w_fall;
    logic [DATA_W-1:0] w_rx_byte;
    logic [DATA_W-1:0] w_dot;
    logic [1:0]        w_next_c;

    assign w_csb     = r_csb_sync[SYNC_STAGES-1];
    assign w_sck     = r_sck_sync[SYNC_STAGES-1];
    assign w_sdi     = r_sdi_sync[SYNC_STAGES-1];
    assign w_rise    = w_sck & ~r_sck_d;
    assign w_fall    = ~w_sck & r_sck_d;
    assign w_rx_byte = {r_rx_sr, w_sdi};
    // result byte to load after finishing read byte r_byte_cnt (8 -> C1, ...)
    assign w_next_c  = 2'(r_byte_cnt - 4'd7);

    // One dot2 shared across the four compute cycles
    matmul_dot2 #(.DATA_W(DATA_W)) u_dot2 (
        .i_a (r_a[idx_a0(r_cmp_cnt)]),
        .i_b (r_b[idx_b0(r_cmp_cnt)]),
        .i_c (r_a[idx_a1(r_cmp_cnt)]),
        .i_d (r_b[idx_b1(r_cmp_cnt)]),
        .o_y (w_dot)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_csb_sync  <= '1;
            r_sck_sync  <= '0;
            r_sdi_sync  <= '0;
            r_sck_d     <= 1'b0;
            r_state     <= ST_IDLE;
            r_byte_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_cmp_cnt   <= '0;
            r_rx_sr     <= '0;
            r_tx_sr     <= '0;
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_rise_seen <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
                r_c[i] <= '0;
            end
        end else begin
            // Identical synchronisers keep sck and sdi aligned
            r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], spi_csb};
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi_sdi};
            r_sck_d    <= w_sck;

            if (w_csb) begin
                // Deselect beats any coincident sck edge; data registers are kept
                r_state     <= ST_IDLE;
                r_byte_cnt  <= '0;
                r_bit_cnt   <= '0;
                r_tx_sr     <= '0;
                r_busy      <= 1'b0;
                r_rise_seen <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE, ST_RX: begin
                        // A rise arriving with the first selected cycle is not lost
                        r_state <= ST_RX;
                        if (w_rise) begin
                            r_busy  <= 1'b1;
                            r_rx_sr <= w_rx_byte[DATA_W-2:0];
                            if (r_bit_cnt == 3'(DATA_W-1)) begin
                                r_bit_cnt <= '0;
                                if (r_byte_cnt[2])
                                    r_b[r_byte_cnt[1:0]] <= w_rx_byte;
                                else
                                    r_a[r_byte_cnt[1:0]] <= w_rx_byte;
                                if (r_byte_cnt == 4'd0)
                                    r_valid <= 1'b0;
                                r_byte_cnt <= r_byte_cnt + 4'd1;
                                if (r_byte_cnt == 4'(N_IN_BYTES-1)) begin
                                    r_state     <= ST_COMPUTE;
                                    r_cmp_cnt   <= '0;
                                    r_rise_seen <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end

                    ST_COMPUTE: begin
                        r_c[r_cmp_cnt] <= w_dot;
                        r_cmp_cnt      <= r_cmp_cnt + 2'd1;
                        // Early master clock: data dropped but the bit is counted
                        if (w_rise) begin
                            r_bit_cnt   <= r_bit_cnt + 3'd1;
                            r_rise_seen <= 1'b1;
                        end
                        if (r_cmp_cnt == 2'(N_OUT_BYTES-1)) begin
                            r_valid <= 1'b1;
                            r_tx_sr <= r_c[0];
                            r_state <= ST_TX;
                        end
                    end

                    ST_TX, ST_DONE: begin
                        // The fall that closes the last write byte must not shift
                        // C0, so falls only count once a read-phase rise was seen.
                        if (w_rise)
                            r_rise_seen <= 1'b1;
                        if (w_fall && r_rise_seen) begin
                            if (r_bit_cnt == 3'(DATA_W-1)) begin
                                r_bit_cnt <= '0;
                                if (r_state == ST_TX) begin
                                    r_byte_cnt <= r_byte_cnt + 4'd1;
                                    if (r_byte_cnt == 4'(BYTE_CNT_MAX-1)) begin
                                        r_state <= ST_DONE;
                                        r_busy  <= 1'b0;
                                        r_tx_sr <= '0;
                                    end else begin
                                        r_tx_sr <= r_c[w_next_c];
                                    end
                                end else begin
                                    r_tx_sr <= '0;
                                    if (r_byte_cnt != 4'(BYTE_CNT_MAX))
                                        r_byte_cnt <= r_byte_cnt + 4'd1;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                                r_tx_sr   <= {r_tx_sr[DATA_W-2:0], 1'b0};
                            end
                        end
                    end

                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign spi_sdo      = ((r_state == ST_TX) || (r_state == ST_DONE)) ? r_tx_sr[DATA_W-1] : 1'b0;
    assign busy         = r_busy;
    assign result_valid = r_valid;

endmodule

// File: tb/tb_spi_matmul_slave.sv
// Directed self-checking bench for spi_matmul_slave: SPI master model with
// sck period SPI_DIV clk cycles, hand-computed expected result bytes.
module tb_spi_matmul_slave;

    localparam int SPI_DIV = 40;
    localparam int HALF    = SPI_DIV / 2;

`ifdef MATMUL_SAT_EN
    localparam logic [7:0] EXP_FF = 8'hFF;
`else
    localparam logic [7:0] EXP_FF = 8'h02;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic spi_csb = 1'b1;
    logic spi_sck = 1'b0;
    logic spi_sdi = 1'b0;
    logic spi_sdo, busy, result_valid;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_b [16];
    logic [7:0] rx_b [16];
    logic       snap_v [17];
    logic       snap_b [17];
    logic [3:0] cnt_end;

    spi_matmul_slave #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .spi_csb      (spi_csb),
        .spi_sck      (spi_sck),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .busy         (busy),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Shift nbits of tx (MSB first); rx captures sdo just before each rise.
    // v/b snapshot result_valid/busy at the first sample point.
    task automatic spi_byte(input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx, output logic v, output logic b);
        rx = 8'h00;
        v  = 1'b0;
        b  = 1'b0;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_sdi = tx[i];
            repeat (HALF) @(negedge clk);
            if (i == 7) begin
                v = result_valid;
                b = busy;
            end
            rx[i] = spi_sdo;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic set_frame(input logic [31:0] a, input logic [31:0] b);
        for (int i = 0; i < 16; i++) tx_b[i] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            tx_b[i]     = a[31-8*i -: 8];
            tx_b[i + 4] = b[31-8*i -: 8];
        end
    endtask

    task automatic run_frame(input int n);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < n; i++)
            spi_byte(tx_b[i], 8, rx_b[i], snap_v[i], snap_b[i]);
        repeat (HALF) @(negedge clk);
        snap_v[n] = result_valid;
        snap_b[n] = busy;
        cnt_end   = dut.r_byte_cnt;
        spi_csb = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic check_results(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                                 input logic [7:0] e2, input logic [7:0] e3);
        logic [7:0] exp_c [4];
        exp_c[0] = e0; exp_c[1] = e1; exp_c[2] = e2; exp_c[3] = e3;
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (rx_b[8 + k] !== exp_c[k]) begin
                n_fail++;
                $display("FAIL %s C%0d: got %h expected %h", tag, k, rx_b[8 + k], exp_c[k]);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (spi_sdo !== 1'b0) begin n_fail++; $display("FAIL reset_sdo: got %b expected 0", spi_sdo); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++;
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", result_valid); end
        resetn = 1'b1;
        // sck activity with CSB high must not start a transaction
        for (int i = 0; i < 16; i++) begin
            spi_sdi = i[0];
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
        n_tests++;
        if (spi_sdo !== 1'b0) begin n_fail++; $display("FAIL idle_sdo: got %b expected 0", spi_sdo); end
        n_tests++;
        if (dut.r_state !== 3'd0) begin n_fail++; $display("FAIL idle_state: got %0d expected 0", dut.r_state); end
    endtask

    task automatic test_basic();
        set_frame(32'h01020304, 32'h05060708);
        run_frame(12);
        check_results("basic", 8'h13, 8'h16, 8'h2B, 8'h32);
        n_tests++;
        if (snap_v[8] !== 1'b1) begin n_fail++; $display("FAIL basic_valid_after8: got %b expected 1", snap_v[8]); end
        n_tests++;
        if (snap_b[1] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rx: got %b expected 1", snap_b[1]); end
        n_tests++;
        if (snap_b[10] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_tx: got %b expected 1", snap_b[10]); end
    endtask

    task automatic test_overflow();
        set_frame(32'hFFFFFFFF, 32'hFFFFFFFF);
        run_frame(12);
        check_results("overflow", EXP_FF, EXP_FF, EXP_FF, EXP_FF);
    endtask

    task automatic test_abort();
        logic [7:0] dummy;
        logic       dv, db;
        set_frame(32'h11223344, 32'h55667788);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(tx_b[0], 8, dummy, dv, db);
        spi_byte(tx_b[1], 8, dummy, dv, db);
        spi_byte(tx_b[2], 3, dummy, dv, db);
        spi_csb = 1'b1;
        repeat (10) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        set_frame(32'h01020304, 32'h05060708);
        run_frame(12);
        check_results("abort_fresh", 8'h13, 8'h16, 8'h2B, 8'h32);
    endtask

    task automatic test_long_frame();
        set_frame(32'h01020304, 32'h05060708);
        run_frame(14);
        check_results("long", 8'h13, 8'h16, 8'h2B, 8'h32);
        n_tests++;
        if (rx_b[12] !== 8'h00) begin n_fail++; $display("FAIL long_byte12: got %h expected 00", rx_b[12]); end
        n_tests++;
        if (rx_b[13] !== 8'h00) begin n_fail++; $display("FAIL long_byte13: got %h expected 00", rx_b[13]); end
        n_tests++;
        if (cnt_end !== 4'd12) begin n_fail++; $display("FAIL long_byte_cnt: got %0d expected 12", cnt_end); end
        n_tests++;
        if (snap_b[11] !== 1'b1) begin n_fail++; $display("FAIL long_busy_byte11: got %b expected 1", snap_b[11]); end
        n_tests++;
        if (snap_b[12] !== 1'b0) begin n_fail++; $display("FAIL long_busy_after11: got %b expected 0", snap_b[12]); end
    endtask

    task automatic test_reset_in_compute();
        logic [7:0] dummy;
        logic       dv, db;
        set_frame(32'h02030405, 32'h01010101);
        spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 7; i++) spi_byte(tx_b[i], 8, dummy, dv, db);
        spi_byte(tx_b[7], 7, dummy, dv, db);
        // last write bit: rise, then reset while the compute cycles run
        spi_sdi = tx_b[7][0];
        repeat (HALF) @(negedge clk);
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL rstcmp_busy_before: got %b expected 1", busy); end
        resetn = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstcmp_busy: got %b expected 0", busy); end
        n_tests++;
        if (spi_sdo !== 1'b0) begin n_fail++; $display("FAIL rstcmp_sdo: got %b expected 0", spi_sdo); end
        n_tests++;
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL rstcmp_valid: got %b expected 0", result_valid); end
        spi_sck = 1'b0;
        spi_csb = 1'b1;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (10) @(negedge clk);
        set_frame(32'h01020304, 32'h05060708);
        run_frame(12);
        check_results("rstcmp_next", 8'h13, 8'h16, 8'h2B, 8'h32);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_abort();
        test_long_frame();
        test_reset_in_compute();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
